uart_rx_fifo: RTL

Parametrised successor to the single-byte UART receiver that feeds the BLE link into gameplay. Deserialises an async serial line at a configurable bit period and data width. Buffers received words in a first-word-fall-through FIFO so that bursts are not lost between frames. Provides flow control, overflow and framing-error reporting. Sits on clk_pixel between the BLE UART pins and the gameplay user_input/user_rdy interface.

---
 rtl/uart_rx_fifo.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver (2-FF synchronised rx, configurable bit period
//               and width) feeding a first-word-fall-through FIFO with CTS
//               flow control, sticky overflow and error pulses.
//               Optional feature macro: UART_RX_PARITY_EN (adds parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int BAUD_COUNT = 645,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CTS_MARGIN = 2,
    parameter int ODD_PARITY = 0
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rx_in,
    input  logic                             rd_in,
    output logic [DATA_BITS-1:0]             data_out,
    output logic                             valid_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_out,
    output logic                             cts_out,
    output logic                             overflow_out,
    output logic                             frame_err_out,
    output logic                             parity_err_out
);

    localparam int c_TW = $clog2(BAUD_COUNT);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_BW = $clog2(DATA_BITS);

    localparam logic [c_TW-1:0] c_T_HALF = c_TW'(BAUD_COUNT / 2);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(BAUD_COUNT - 1);
    localparam logic [c_BW-1:0] c_B_LAST = c_BW'(DATA_BITS - 1);
    localparam logic [c_CW-1:0] c_FULL   = c_CW'(FIFO_DEPTH);

    if (BAUD_COUNT < 4) begin : g_chk_baud
        $error("BAUD_COUNT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
        $error("DATA_BITS must be in 5..9");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of two in 2..256");
    end
    if (CTS_MARGIN < 0 || CTS_MARGIN >= FIFO_DEPTH) begin : g_chk_margin
        $error("CTS_MARGIN must be below FIFO_DEPTH");
    end
    if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_chk_odd
        $error("ODD_PARITY must be 0 or 1");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
    localparam logic c_ODD = (ODD_PARITY != 0);
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    state_t                r_state;
    logic [c_TW-1:0]       r_timer;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                  r_par_bad;
    logic                  r_parity_err;
    logic                  w_par_exp;
`endif

    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_cts;
    logic                  r_overflow;

    logic                  w_stop_sample;
    logic                  w_push_req;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic [c_CW-1:0]       w_free;

    // ------------------------------------------------------------------
    // rx synchroniser; idle-high so reset must not fake a start bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_exp = (^r_shift) ^ c_ODD;
`endif

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= S_START;
                        r_timer <= '0;
                    end
                end
                S_START: begin
                    if (r_timer == c_T_HALF) begin
                        if (r_rx_sync) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_timer   <= '0;
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_timer == c_T_LAST) begin
                        r_timer <= '0;
                        r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_timer == c_T_LAST) begin
                        r_timer   <= '0;
                        r_par_bad <= (r_rx_sync != w_par_exp);
                        r_state   <= S_STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_timer == c_T_LAST) begin
                        r_timer     <= '0;
                        r_state     <= S_IDLE;
                        r_frame_err <= ~r_rx_sync;
`ifdef UART_RX_PARITY_EN
                        // framing error takes precedence over parity
                        r_parity_err <= r_rx_sync & r_par_bad;
`endif
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_stop_sample = (r_state == S_STOP) && (r_timer == c_T_LAST);
`ifdef UART_RX_PARITY_EN
    assign w_push_req    = w_stop_sample & r_rx_sync & ~r_par_bad;
`else
    assign w_push_req    = w_stop_sample & r_rx_sync;
`endif
    assign w_pop  = rd_in & (r_count != '0);
    assign w_full = (r_count == c_FULL);
    // When full, a same-cycle pop frees the slot the push lands in
    assign w_wr   = w_push_req & (~w_full | w_pop);
    assign w_free = c_FULL - r_count;

    always_ff @(posedge clk_in) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cts      <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_cts <= (int'(w_free) > CTS_MARGIN);
        end
    end

    assign valid_out     = (r_count != '0);
    assign data_out      = valid_out ? r_mem[r_rd_ptr] : '0;
    assign count_out     = r_count;
    assign cts_out       = r_cts;
    assign overflow_out  = r_overflow;
    assign frame_err_out = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err_out = r_parity_err;
`else
    assign parity_err_out = 1'b0;
`endif

endmodule
`default_nettype wire
